// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_if
//  Purpose  : Requester-side and memory-side bundle for the dmem arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  wr;
    logic [11:0] addr0;
    logic [11:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;

    modport slave (
        input  req, lock, wr, addr0, addr1, wdata0, wdata1, q_dmem,
        output gnt, rvalid, rdata, address_dmem, data, wren
    );

    modport master (
        output req, lock, wr, addr0, addr1, wdata0, wdata1, q_dmem,
        input  gnt, rvalid, rdata, address_dmem, data, wren
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Round-robin arbiter with bounded lock sharing one synchronous
//             data memory between the processor (0) and debug port (1).
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int READ_LAT  = 1,
    parameter int MAX_BURST = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam logic [7:0] c_max_burst = 8'(MAX_BURST);
    localparam logic [7:0] c_burst_sat = 8'hFF;

    logic                r_last_winner;
    logic [7:0]          r_burst_cnt;
    logic                r_prev_gnt;
    logic                r_prev_lock;
    logic [11:0]         r_addr;
    logic [31:0]         r_data;
    logic [READ_LAT-1:0] r_pipe_vld;
    logic [READ_LAT-1:0] r_pipe_id;

    logic                w_lock_on;
    logic                w_any;
    logic                w_win;
    logic [11:0]         w_addr;
    logic [31:0]         w_data;

    // Lock only survives back-to-back grants; any idle cycle clears r_prev_gnt.
    always_comb begin
        w_lock_on = r_prev_gnt && r_prev_lock && bus.req[r_last_winner]
                    && (r_burst_cnt < c_max_burst);
        w_any     = 1'b0;
        w_win     = 1'b0;
        if (!rst) begin
            case (bus.req)
                2'b01: begin
                    w_any = 1'b1;
                    w_win = 1'b0;
                end
                2'b10: begin
                    w_any = 1'b1;
                    w_win = 1'b1;
                end
                2'b11: begin
                    w_any = 1'b1;
                    w_win = w_lock_on ? r_last_winner : ~r_last_winner;
                end
                default: begin
                    w_any = 1'b0;
                    w_win = 1'b0;
                end
            endcase
        end
    end

    assign w_addr           = w_win ? bus.addr1  : bus.addr0;
    assign w_data           = w_win ? bus.wdata1 : bus.wdata0;
    assign bus.gnt          = {w_any & w_win, w_any & ~w_win};
    assign bus.wren         = w_any & bus.wr[w_win];
    assign bus.address_dmem = w_any ? w_addr : r_addr;
    assign bus.data         = w_any ? w_data : r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_winner <= 1'b1;
            r_burst_cnt   <= 8'd0;
            r_prev_gnt    <= 1'b0;
            r_prev_lock   <= 1'b0;
            r_addr        <= 12'd0;
            r_data        <= 32'd0;
        end else begin
            if (w_any) begin
                r_last_winner <= w_win;
                r_prev_lock   <= bus.lock[w_win];
                r_addr        <= w_addr;
                r_data        <= w_data;
                if (r_prev_gnt && (w_win == r_last_winner)) begin
                    if (r_burst_cnt != c_burst_sat) begin
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                    end
                end else begin
                    r_burst_cnt <= 8'd1;
                end
            end
            r_prev_gnt <= w_any;
        end
    end

    // Read tags travel alongside the memory's own read pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            r_pipe_vld[0] <= w_any & ~bus.wr[w_win];
            r_pipe_id[0]  <= w_win;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

    assign bus.rvalid = {r_pipe_vld[READ_LAT-1] &  r_pipe_id[READ_LAT-1],
                         r_pipe_vld[READ_LAT-1] & ~r_pipe_id[READ_LAT-1]};
    assign bus.rdata  = bus.q_dmem;

endmodule
`default_nettype wire
